// File: rtl/uart_baud_pkg.sv
// Shared constants for the UART baud/oversample generator: preset bit-period
// table (CLK cycles per bit), preset selectors and divisor-source modes.
package uart_baud_pkg;

  localparam int unsigned BAUD_PRESET [0:7] = '{
    32'd1920, 32'd960, 32'd480, 32'd320, 32'd160, 32'd80, 32'd40, 32'd20
  };

  localparam logic [2:0] SEL_9600   = 3'd0;
  localparam logic [2:0] SEL_19200  = 3'd1;
  localparam logic [2:0] SEL_38400  = 3'd2;
  localparam logic [2:0] SEL_57600  = 3'd3;
  localparam logic [2:0] SEL_115200 = 3'd4;
  localparam logic [2:0] SEL_230400 = 3'd5;
  localparam logic [2:0] SEL_460800 = 3'd6;
  localparam logic [2:0] SEL_921600 = 3'd7;

  localparam logic MODE_PRESET = 1'b0;
  localparam logic MODE_CUSTOM = 1'b1;

  // Bit period of a preset, usable in constant and runtime contexts alike.
  function automatic int unsigned preset_period(input logic [2:0] sel);
    return BAUD_PRESET[sel];
  endfunction

endpackage

// File: rtl/baud_preset_lut.sv
// Combinational preset-index to bit-period lookup, shared with the TX/RX
// configuration logic.
module baud_preset_lut
  import uart_baud_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic [2:0]       sel,
  output logic [CNT_W-1:0] period
);

  always_comb begin
    period = CNT_W'(BAUD_PRESET[0]);
    case (sel)
      SEL_9600:   period = CNT_W'(BAUD_PRESET[0]);
      SEL_19200:  period = CNT_W'(BAUD_PRESET[1]);
      SEL_38400:  period = CNT_W'(BAUD_PRESET[2]);
      SEL_57600:  period = CNT_W'(BAUD_PRESET[3]);
      SEL_115200: period = CNT_W'(BAUD_PRESET[4]);
      SEL_230400: period = CNT_W'(BAUD_PRESET[5]);
      SEL_460800: period = CNT_W'(BAUD_PRESET[6]);
      SEL_921600: period = CNT_W'(BAUD_PRESET[7]);
      default:    period = CNT_W'(BAUD_PRESET[0]);
    endcase
  end

endmodule

// File: rtl/uart_baud_os_gen.sv
// Baud generator: a fractional accumulator spreads OVERSAMPLE os_ticks evenly
// over a bit period P, with baud_tick/baud_clk derived from the tick count.
module uart_baud_os_gen
  import uart_baud_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_SEL = 0
) (
  input  logic             CLK,
  input  logic             reset_external,
  input  logic             enable,
  input  logic             resync,
  input  logic             cfg_load,
  input  logic             mode,
  input  logic [2:0]       sel,
  input  logic [CNT_W-1:0] div_custom,
  output logic             os_tick,
  output logic             baud_tick,
  output logic             baud_clk,
  output logic             cfg_pending,
  output logic             cfg_err
);

  localparam int ACC_W = CNT_W + 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  localparam logic [ACC_W-1:0] OS_INC     = ACC_W'(OVERSAMPLE);
  localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF    = OS_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(OVERSAMPLE);
  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(BAUD_PRESET[DEFAULT_SEL]);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             os_tick_q, os_tick_d;
  logic             baud_tick_q, baud_tick_d;
  logic             baud_clk_q, baud_clk_d;
  logic             pending_q, pending_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] lut_period_s;
  logic [CNT_W-1:0] cfg_period_s;
  logic             cfg_valid_s;
  logic [ACC_W-1:0] sum_s;
  logic [ACC_W-1:0] period_ext_s;
  logic             fire_s;
  logic             wrap_s;

  baud_preset_lut #(
    .CNT_W (CNT_W)
  ) u_lut (
    .sel    (sel),
    .period (lut_period_s)
  );

  assign cfg_period_s = (mode == MODE_CUSTOM) ? div_custom : lut_period_s;
  assign cfg_valid_s  = cfg_load && (cfg_period_s >= PERIOD_MIN);
  assign period_ext_s = {1'b0, period_q};
  assign sum_s        = acc_q + OS_INC;
  assign fire_s       = enable && (sum_s >= period_ext_s);
  assign wrap_s       = fire_s && (os_cnt_q == OS_LAST);

  always_comb begin
    acc_d       = acc_q;
    os_cnt_d    = os_cnt_q;
    os_tick_d   = 1'b0;
    baud_tick_d = 1'b0;
    baud_clk_d  = baud_clk_q;
    if (resync) begin
      acc_d      = '0;
      os_cnt_d   = '0;
      baud_clk_d = 1'b1;
    end else if (enable) begin
      if (fire_s) begin
        acc_d     = sum_s - period_ext_s;
        os_tick_d = 1'b1;
        if (wrap_s) begin
          os_cnt_d    = '0;
          baud_tick_d = 1'b1;
        end else begin
          os_cnt_d = os_cnt_q + OS_W'(1);
        end
      end else begin
        acc_d = sum_s;
      end
      baud_clk_d = (os_cnt_d < OS_HALF);
    end else begin
      acc_d    = acc_q;
      os_cnt_d = os_cnt_q;
    end
  end

  // A period change lands at the bit boundary while running, immediately when
  // stopped or resynchronising; the newest accepted load always wins.
  always_comb begin
    period_d  = period_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    err_d     = err_q;
    if (cfg_load) begin
      if (cfg_valid_s) begin
        shadow_d = cfg_period_s;
        err_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = err_q;
    end
    if (resync) begin
      if (cfg_valid_s) begin
        period_d = cfg_period_s;
      end else if (pending_q) begin
        period_d = shadow_q;
      end else begin
        period_d = period_q;
      end
      pending_d = 1'b0;
    end else if (!enable) begin
      if (cfg_valid_s) begin
        period_d  = cfg_period_s;
        pending_d = 1'b0;
      end else begin
        period_d = period_q;
      end
    end else begin
      if (wrap_s && pending_q) begin
        period_d  = shadow_q;
        pending_d = 1'b0;
      end else begin
        period_d = period_q;
      end
      if (cfg_valid_s) begin
        pending_d = 1'b1;
      end else begin
        pending_d = pending_d;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset_external) begin
    if (reset_external) begin
      acc_q       <= '0;
      os_cnt_q    <= '0;
      period_q    <= PERIOD_RST;
      shadow_q    <= PERIOD_RST;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      baud_clk_q  <= 1'b1;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      os_cnt_q    <= os_cnt_d;
      period_q    <= period_d;
      shadow_q    <= shadow_d;
      os_tick_q   <= os_tick_d;
      baud_tick_q <= baud_tick_d;
      baud_clk_q  <= baud_clk_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
    end
  end

  assign os_tick     = os_tick_q;
  assign baud_tick   = baud_tick_q;
  assign baud_clk    = baud_clk_q;
  assign cfg_pending = pending_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_uart_baud_os_gen.sv
// Bench for uart_baud_os_gen: phase-arithmetic reference model compared every
// cycle, directed literal checks, then randomized enable/resync/cfg traffic.
module tb_uart_baud_os_gen;

  localparam int OS = 16;

  logic        CLK = 1'b0;
  logic        reset_external;
  logic        enable = 1'b0;
  logic        resync = 1'b0;
  logic        cfg_load = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [15:0] div_custom = 16'd0;
  logic        os_tick, baud_tick, baud_clk, cfg_pending, cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_baud_os_gen #(
    .CNT_W       (16),
    .OVERSAMPLE  (OS),
    .DEFAULT_SEL (0)
  ) dut (
    .CLK            (CLK),
    .reset_external (reset_external),
    .enable         (enable),
    .resync         (resync),
    .cfg_load       (cfg_load),
    .mode           (mode),
    .sel            (sel),
    .div_custom     (div_custom),
    .os_tick        (os_tick),
    .baud_tick      (baud_tick),
    .baud_clk       (baud_clk),
    .cfg_pending    (cfg_pending),
    .cfg_err        (cfg_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int preset(input logic [2:0] s);
    case (s)
      3'd0: return 1920;
      3'd1: return 960;
      3'd2: return 480;
      3'd3: return 320;
      3'd4: return 160;
      3'd5: return 80;
      3'd6: return 40;
      default: return 20;
    endcase
  endfunction

  // Model: n enabled cycles and k ticks into the current bit; tick k+1 is due
  // once n*OS reaches (k+1)*P, the OS-th tick closes the bit.
  int m_n = 0, m_k = 0, m_p = 1920, m_sh = 1920;
  bit m_pend = 0, m_err = 0, m_os = 0, m_bt = 0, m_clk = 1;

  always @(posedge CLK or posedge reset_external) begin
    if (reset_external) begin
      m_n = 0; m_k = 0; m_p = 1920; m_sh = 1920;
      m_pend = 0; m_err = 0; m_os = 0; m_bt = 0; m_clk = 1;
    end else begin
      int cp, old_sh;
      bit v, old_pend;
      cp = mode ? int'(div_custom) : preset(sel);
      v = cfg_load && (cp >= OS);
      old_sh = m_sh;
      old_pend = m_pend;
      m_os = 0;
      m_bt = 0;
      if (cfg_load) begin
        m_err = !v;
        if (v) m_sh = cp;
      end
      if (resync) begin
        m_n = 0; m_k = 0;
        if (v) m_p = cp;
        else if (old_pend) m_p = old_sh;
        m_pend = 0;
      end else if (enable) begin
        m_n++;
        if (m_n * OS >= (m_k + 1) * m_p) begin
          m_os = 1;
          m_k++;
          if (m_k == OS) begin
            m_bt = 1; m_k = 0; m_n = 0;
            if (old_pend) begin m_p = old_sh; m_pend = 0; end
          end
        end
        if (v) m_pend = 1;
      end else if (v) begin
        m_p = cp;
        m_pend = 0;
      end
      m_clk = (m_k < OS / 2);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge CLK);
      checks++;
      if ({os_tick, baud_tick, baud_clk, cfg_pending, cfg_err} !==
          {m_os, m_bt, m_clk, m_pend, m_err}) begin
        errors++;
        $display("FAIL model_cmp cycle %0d: dut os/bt/clk/pend/err=%b model=%b", cyc,
                 {os_tick, baud_tick, baud_clk, cfg_pending, cfg_err},
                 {m_os, m_bt, m_clk, m_pend, m_err});
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_os(input string name, output int at);
    at = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      if (os_tick) begin at = cyc; break; end
    end
    if (at < 0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_bt(input string name, output int at);
    at = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      if (baud_tick) begin at = cyc; break; end
    end
    if (at < 0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic load(input logic m, input logic [2:0] s, input logic [15:0] d);
    cfg_load = 1'b1; mode = m; sel = s; div_custom = d;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    int c0, t1, t2, t3, t4, t5, t6, t7, tr, at, nos, lastbt;
    int pos[4];
    bit frozen, quiet;
    reset_external = 1'b1;
    repeat (3) tick();
    fork compare_loop(); join_none
    chk("reset_outputs", int'({os_tick, baud_tick, baud_clk, cfg_pending, cfg_err}), 5'b00100);

    // Default preset 1920: first tick at 120, bit 1920, baud_clk high 960.
    reset_external = 1'b0;
    enable = 1'b1;
    c0 = cyc;
    wait_os("first_os", at);
    chk("first_os_latency", at - c0, 120);
    wait_bt("bt1", t1);
    chk("first_bt_latency", t1 - c0, 1920);
    at = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!baud_clk) begin at = cyc; break; end
    end
    chk("baud_clk_high", at - t1, 960);
    wait_bt("bt2", t2);
    chk("bt_period_1920", t2 - t1, 1920);

    // Switch to P=40 mid-bit; applied at the next boundary.
    repeat (100) tick();
    load(1'b0, 3'd6, 16'd0);
    chk("pending_set", int'(cfg_pending), 1);
    wait_bt("bt3", t3);
    chk("pending_clear_at_bt", int'(cfg_pending), 0);
    nos = 0; lastbt = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (os_tick) begin
        if (nos < 4) pos[nos] = i;
        nos++;
      end
      if (baud_tick) lastbt = i;
    end
    chk("p40_os1", pos[0], 3);
    chk("p40_os2", pos[1], 5);
    chk("p40_os3", pos[2], 8);
    chk("p40_os4", pos[3], 10);
    chk("p40_os_count", nos, 16);
    chk("p40_bt_at", lastbt, 40);

    // Rejected custom divisor, then an accepted one.
    load(1'b1, 3'd0, 16'd10);
    chk("err_on_small_div", int'({cfg_err, cfg_pending}), 2'b10);
    load(1'b1, 3'd0, 16'd100);
    chk("err_clear_pending", int'({cfg_err, cfg_pending}), 2'b01);
    wait_bt("bt4", t4);
    wait_bt("bt5", t5);
    chk("bt_period_100", t5 - t4, 100);

    // Resync after 10 ticks of a bit.
    for (int i = 0; i < 10; i++) wait_os("os_pre_resync", at);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    tr = cyc;
    chk("resync_outputs", int'({os_tick, baud_tick, baud_clk}), 3'b001);
    wait_bt("bt6", t6);
    chk("resync_to_bt", t6 - tr, 100);

    // Enable low for 50 cycles mid-bit.
    repeat (30) tick();
    frozen = baud_clk;
    enable = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (os_tick || baud_tick || (baud_clk != frozen)) quiet = 1'b0;
    end
    chk("disabled_quiet", int'(quiet), 1);
    enable = 1'b1;
    wait_bt("bt7", t7);
    chk("bit_with_pause", t7 - t6, 150);

    // Randomized traffic; stopped-clock loads only paired with resync so the
    // model's bit phase stays meaningful.
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      enable = ($urandom_range(0, 9) != 0);
      resync = ($urandom_range(0, 49) == 0);
      cfg_load = 1'b0;
      if ((enable || resync) && ($urandom_range(0, 29) == 0)) begin
        cfg_load = 1'b1;
        mode = 1'($urandom_range(0, 1));
        sel = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(5, 7));
        div_custom = 16'($urandom_range(4, 130));
      end
    end
    @(negedge CLK);
    enable = 1'b1; resync = 1'b0; cfg_load = 1'b0;

    // Async reset mid-bit with a pending config.
    load(1'b0, 3'd7, 16'd0);
    chk("pending_before_reset", int'(cfg_pending), 1);
    @(posedge CLK);
    #3 reset_external = 1'b1;
    #1 chk("async_reset_outputs", int'({os_tick, baud_tick, baud_clk, cfg_pending, cfg_err}), 5'b00100);
    tick();
    reset_external = 1'b0;
    c0 = cyc;
    wait_os("os_after_reset", at);
    chk("reset_period_1920", at - c0, 120);

    // Load while stopped applies at once without pending.
    enable = 1'b0;
    resync = 1'b1;
    tick();
    resync = 1'b0;
    load(1'b0, 3'd6, 16'd0);
    chk("stopped_load_no_pending", int'({cfg_pending, cfg_err}), 2'b00);
    enable = 1'b1;
    c0 = cyc;
    wait_os("os_after_stopped_load", at);
    chk("stopped_load_latency", at - c0, 3);
    repeat (200) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
